// File: rtl/sdram_burst_dp.sv
// Burst data sequencer for the SDRAM data port: drives oe/datain2 for write bursts and
// returns CAS-delayed read words from sdram_in as a valid-qualified stream.
module sdram_burst_dp #(
  parameter int data_size = 32,
  parameter int max_burst = 8
) (
  input  logic                 clk0_2x,
  input  logic                 reset_n,
  input  logic                 wr_start,
  input  logic                 rd_start,
  input  logic [3:0]           burst_len,
  input  logic [1:0]           cas_lat,
  input  logic [data_size-1:0] wr_data,
  output logic                 wr_ack,
  output logic                 oe,
  output logic [data_size-1:0] datain2,
  input  logic [data_size-1:0] sdram_in,
  output logic [data_size-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {IDLE, WRITE, RD_WAIT, READ, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] wait_cnt, wait_nxt;
  logic       wr_ack_nxt, oe_nxt, rd_valid_nxt, busy_nxt, done_nxt;
  logic       capture_wr, capture_rd;
  logic [3:0] len_eff;
  logic [1:0] lat_eff;

  assign len_eff = (burst_len == 4'd0) ? 4'(max_burst) : burst_len;
  assign lat_eff = (cas_lat == 2'd3) ? 2'd3 : 2'd2;

  // busy is registered, so it also covers the done cycle and blocks a start there.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    wait_nxt     = wait_cnt;
    wr_ack_nxt   = 1'b0;
    oe_nxt       = 1'b0;
    rd_valid_nxt = 1'b0;
    done_nxt     = 1'b0;
    busy_nxt     = (state != IDLE);
    capture_wr   = 1'b0;
    capture_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (!busy) begin
          if (wr_start) begin
            state_nxt  = WRITE;
            cnt_nxt    = len_eff;
            wr_ack_nxt = 1'b1;
          end else if (rd_start) begin
            state_nxt = RD_WAIT;
            cnt_nxt   = len_eff;
            wait_nxt  = lat_eff;
          end
        end
      end
      WRITE: begin
        oe_nxt     = 1'b1;
        capture_wr = 1'b1;
        cnt_nxt    = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = DONE;
        end else begin
          wr_ack_nxt = 1'b1;
        end
      end
      RD_WAIT: begin
        if (wait_cnt == 2'd0) begin
          state_nxt = READ;
        end else begin
          wait_nxt = wait_cnt - 2'd1;
        end
      end
      READ: begin
        rd_valid_nxt = 1'b1;
        capture_rd   = 1'b1;
        cnt_nxt      = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk0_2x or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      wait_cnt <= 2'd0;
      wr_ack   <= 1'b0;
      oe       <= 1'b0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      datain2  <= '0;
      rd_data  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wait_cnt <= wait_nxt;
      wr_ack   <= wr_ack_nxt;
      oe       <= oe_nxt;
      rd_valid <= rd_valid_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      if (capture_wr) begin
        datain2 <= wr_data;
      end
      if (capture_rd) begin
        rd_data <= sdram_in;
      end
    end
  end

endmodule

// File: tb/tb_sdram_burst_dp.sv
// Self-checking bench for sdram_burst_dp: write/read bursts with a host model, a
// latency-delayed port model and scoreboard queues for the expected data words.
module tb_sdram_burst_dp;

  localparam int DW = 32;

  logic          clk0_2x = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_start = 1'b0;
  logic          rd_start = 1'b0;
  logic [3:0]    burst_len = 4'd0;
  logic [1:0]    cas_lat = 2'd0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] sdram_in = '0;
  logic          wr_ack, oe, rd_valid, busy, done;
  logic [DW-1:0] datain2, rd_data;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] rd_q[$];

  sdram_burst_dp #(.data_size(DW), .max_burst(8)) dut (
    .clk0_2x  (clk0_2x),
    .reset_n  (reset_n),
    .wr_start (wr_start),
    .rd_start (rd_start),
    .burst_len(burst_len),
    .cas_lat  (cas_lat),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .oe       (oe),
    .datain2  (datain2),
    .sdram_in (sdram_in),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk0_2x = ~clk0_2x;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Outputs are observed 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk0_2x);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_compared++; if (oe !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_oe: got %b want 0", oe); end
    n_compared++; if (wr_ack !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_wr_ack: got %b want 0", wr_ack); end
    n_compared++; if (rd_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    n_compared++; if (datain2 !== '0) begin n_mismatched++; $display("[TB] FAIL reset_datain2: got %h want 0", datain2); end
    n_compared++; if (rd_data !== '0) begin n_mismatched++; $display("[TB] FAIL reset_rd_data: got %h want 0", rd_data); end
    reset_n = 1'b1;
    tick();
  endtask

  // Host model advances wr_data after every edge at which wr_ack was high.
  task automatic test_write(input int len_field, input logic [DW-1:0] base);
    int len, idx, acks, oe_cycles, done_cnt, done_k;
    logic ack_prev;
    logic [DW-1:0] exp_w;
    len = (len_field == 0) ? 8 : len_field;
    idx = 0; acks = 0; oe_cycles = 0; done_cnt = 0; done_k = -1;
    wr_q.delete();
    for (int i = 0; i < len; i++) wr_q.push_back(base + DW'(i));
    wr_data = base;
    burst_len = 4'(len_field);
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    for (int k = 1; k <= len + 2; k++) begin
      ack_prev = wr_ack;
      tick();
      if (ack_prev) begin
        acks++;
        idx++;
        wr_data = base + DW'(idx);
      end
      if (oe) begin
        oe_cycles++;
        n_compared++;
        if (wr_q.size() == 0) begin
          n_mismatched++;
          $display("[TB] FAIL write_extra_word: got datain2 %h with no word expected", datain2);
        end else begin
          exp_w = wr_q.pop_front();
          if (datain2 !== exp_w) begin
            n_mismatched++;
            $display("[TB] FAIL write_datain2: got %h want %h (cycle %0d)", datain2, exp_w, k);
          end
        end
      end
      if (done) begin done_cnt++; done_k = k; end
      if (k == 1 || k == len + 1) begin
        n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL write_busy_high: got %b want 1 (cycle %0d)", busy, k); end
      end
      if (k == len + 2) begin
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL write_busy_low: got %b want 0", busy); end
      end
    end
    n_compared++; if (oe_cycles != len) begin n_mismatched++; $display("[TB] FAIL write_oe_cycles: got %0d want %0d", oe_cycles, len); end
    n_compared++; if (acks != len) begin n_mismatched++; $display("[TB] FAIL write_ack_count: got %0d want %0d", acks, len); end
    n_compared++; if (done_cnt != 1) begin n_mismatched++; $display("[TB] FAIL write_done_count: got %0d want 1", done_cnt); end
    n_compared++; if (done_k != len + 1) begin n_mismatched++; $display("[TB] FAIL write_done_time: got %0d want %0d", done_k, len + 1); end
    n_compared++; if (datain2 !== base + DW'(len - 1)) begin n_mismatched++; $display("[TB] FAIL write_datain2_hold: got %h want %h", datain2, base + DW'(len - 1)); end
    n_compared++; if (wr_q.size() != 0) begin n_mismatched++; $display("[TB] FAIL write_words_left: got %0d want 0", wr_q.size()); end
  endtask

  // Port model: word j reaches sdram_in so that it is registered at edge T0+C+2+j.
  task automatic test_read(input int len_field, input logic [1:0] cas, input logic [DW-1:0] base);
    int len, c, j, vcnt, first_k, last_k, done_cnt, done_k, oe_hi;
    logic [DW-1:0] exp_w;
    len = (len_field == 0) ? 8 : len_field;
    c = (cas == 2'd3) ? 3 : 2;
    vcnt = 0; first_k = -1; last_k = -1; done_cnt = 0; done_k = -1; oe_hi = 0;
    rd_q.delete();
    burst_len = 4'(len_field);
    cas_lat = cas;
    sdram_in = 32'hDEAD_0000;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int k = 1; k <= c + len + 3; k++) begin
      j = k - c - 2;
      if (j >= 0 && j < len) begin
        sdram_in = base + DW'(j);
        rd_q.push_back(base + DW'(j));
      end else begin
        sdram_in = 32'hDEAD_0000 + DW'(k);
      end
      tick();
      if (oe) oe_hi++;
      if (rd_valid) begin
        vcnt++;
        if (first_k < 0) first_k = k;
        last_k = k;
        n_compared++;
        if (rd_q.size() == 0) begin
          n_mismatched++;
          $display("[TB] FAIL read_extra_word: got rd_data %h with no word expected (cycle %0d)", rd_data, k);
        end else begin
          exp_w = rd_q.pop_front();
          if (rd_data !== exp_w) begin
            n_mismatched++;
            $display("[TB] FAIL read_rd_data: got %h want %h (cycle %0d)", rd_data, exp_w, k);
          end
        end
      end
      if (done) begin done_cnt++; done_k = k; end
    end
    n_compared++; if (first_k != c + 2) begin n_mismatched++; $display("[TB] FAIL read_first_valid: got %0d want %0d", first_k, c + 2); end
    n_compared++; if (vcnt != len) begin n_mismatched++; $display("[TB] FAIL read_valid_count: got %0d want %0d", vcnt, len); end
    n_compared++; if (last_k - first_k + 1 != len) begin n_mismatched++; $display("[TB] FAIL read_contiguous: got span %0d want %0d", last_k - first_k + 1, len); end
    n_compared++; if (done_cnt != 1) begin n_mismatched++; $display("[TB] FAIL read_done_count: got %0d want 1", done_cnt); end
    n_compared++; if (done_k != c + len + 2) begin n_mismatched++; $display("[TB] FAIL read_done_time: got %0d want %0d", done_k, c + len + 2); end
    n_compared++; if (oe_hi != 0) begin n_mismatched++; $display("[TB] FAIL read_oe_low: got %0d oe cycles want 0", oe_hi); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL read_busy_end: got %b want 0", busy); end
  endtask

  // Simultaneous starts, then rd_start pulses mid-burst and during the done cycle.
  task automatic test_priority();
    int oe_cycles, rv_cycles, done_cnt;
    oe_cycles = 0; rv_cycles = 0; done_cnt = 0;
    wr_data = 32'h5A5A_0001;
    burst_len = 4'd3;
    cas_lat = 2'd3;
    wr_start = 1'b1;
    rd_start = 1'b1;
    tick();
    wr_start = 1'b0;
    rd_start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      rd_start = (k == 2 || k == 4);
      if (oe) oe_cycles++;
      if (rd_valid) rv_cycles++;
      if (done) done_cnt++;
    end
    rd_start = 1'b0;
    n_compared++; if (oe_cycles != 3) begin n_mismatched++; $display("[TB] FAIL prio_oe_cycles: got %0d want 3", oe_cycles); end
    n_compared++; if (rv_cycles != 0) begin n_mismatched++; $display("[TB] FAIL prio_no_read: got %0d rd_valid cycles want 0", rv_cycles); end
    n_compared++; if (done_cnt != 1) begin n_mismatched++; $display("[TB] FAIL prio_done_count: got %0d want 1", done_cnt); end
  endtask

  // test_write returns on the first IDLE cycle after done, so the read starts there.
  task automatic test_back_to_back();
    test_write(2, 32'hD000_0000);
    n_compared++; if (oe !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_turnaround_oe: got %b want 0", oe); end
    test_read(2, 2'd2, 32'hE000_0000);
  endtask

  task automatic test_reset_midburst();
    int late_done, late_oe;
    late_done = 0; late_oe = 0;
    wr_data = 32'h7700_0000;
    burst_len = 4'd8;
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    tick();
    tick();
    n_compared++; if (oe !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midrst_oe_before: got %b want 1", oe); end
    #2 reset_n = 1'b0;
    #1;
    n_compared++; if (oe !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_oe_async: got %b want 0", oe); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_busy_async: got %b want 0", busy); end
    n_compared++; if (wr_ack !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_wr_ack_async: got %b want 0", wr_ack); end
    n_compared++; if (datain2 !== '0) begin n_mismatched++; $display("[TB] FAIL midrst_datain2_async: got %h want 0", datain2); end
    #2 reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) late_done++;
      if (oe) late_oe++;
    end
    n_compared++; if (late_done != 0) begin n_mismatched++; $display("[TB] FAIL midrst_no_done: got %0d done pulses want 0", late_done); end
    n_compared++; if (late_oe != 0) begin n_mismatched++; $display("[TB] FAIL midrst_no_resume: got %0d oe cycles want 0", late_oe); end
  endtask

  initial begin
    $display("[TB] starting sdram_burst_dp bench");
    test_reset();
    test_write(4, 32'hA000_0000);
    test_read(0, 2'd3, 32'hB000_0000);
    test_read(1, 2'd1, 32'hC000_0000);
    test_priority();
    test_back_to_back();
    test_write(1, 32'hF000_0000);
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
